// File: rtl/register_file_pkg.sv
// Shared constants and types for the
// RV32I integer register file.
package register_file_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = $clog2(REG_COUNT);

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_t;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/register_file_clear_ctrl.sv
// Post-reset clear sequencer: walks x1..xN-1
// writing zero, then raises init_done.
module register_file_clear_ctrl
  import register_file_pkg::*;
#(
  parameter int NUM_REGS = REG_COUNT,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_ready,
  output logic              o_init_done
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_REGS - 1);

  rf_state_t         r_state;
  rf_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [ADDR_W-1:0] w_clr_idx_nxt;
  logic              r_init_done;
  logic              w_init_done_nxt;
  logic              w_clearing;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RF_CLEAR;
      r_clr_idx   <= ADDR_W'(1);
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_idx   <= w_clr_idx_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_clr_idx_nxt   = r_clr_idx;
    w_init_done_nxt = r_init_done;
    w_clearing      = 1'b0;
    unique case (r_state)
      RF_CLEAR: begin
        w_clearing    = 1'b1;
        w_clr_idx_nxt = r_clr_idx + 1'b1;
        if (r_clr_idx == LAST) begin
          w_state_nxt     = RF_READY;
          w_init_done_nxt = 1'b1;
          w_clr_idx_nxt   = r_clr_idx;
        end
      end
      RF_READY: ;
      default: ;
    endcase
  end

  // A reset edge must not itself disturb the array
  assign o_clr_we    = w_clearing && !rst;
  assign o_clr_addr  = r_clr_idx;
  assign o_ready     = (r_state == RF_READY);
  assign o_init_done = r_init_done;

endmodule

// File: rtl/register_file.sv
// RV32I register file: 2 comb read ports,
// 1 sync write port, x0 fixed at zero.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_W,
  parameter int NUM_REGS   = REG_COUNT,
  parameter int BYPASS     = 1,
  localparam int ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_reg,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_reg_1,
  input  logic [ADDR_W-1:0]     rd_reg_2,
  output logic [DATA_WIDTH-1:0] rd_data_1,
  output logic [DATA_WIDTH-1:0] rd_data_2,
  output logic                  init_done
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                  w_clr_we;
  logic [ADDR_W-1:0]     w_clr_addr;
  logic                  w_ready;
  logic                  w_user_we;
  logic                  w_we;
  logic [ADDR_W-1:0]     w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [ADDR_W-1:0]     w_rd_addr [2];
  logic [DATA_WIDTH-1:0] w_rd_data [2];

  register_file_clear_ctrl #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_clr (
    .clk         (clk),
    .rst         (rst),
    .o_clr_we    (w_clr_we),
    .o_clr_addr  (w_clr_addr),
    .o_ready     (w_ready),
    .o_init_done (init_done)
  );

  assign w_user_we = w_ready && !rst && wr_en &&
                     (wr_reg != '0) &&
                     (32'(wr_reg) < NUM_REGS);

  assign w_we    = w_clr_we || w_user_we;
  assign w_waddr = w_clr_we ? w_clr_addr : wr_reg;
  assign w_wdata = w_clr_we ? '0 : wr_data;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_regs[w_waddr] <= w_wdata;
    end
  end

  assign w_rd_addr[0] = rd_reg_1;
  assign w_rd_addr[1] = rd_reg_2;

  // x0, out-of-range and CLEAR all read zero
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      w_rd_data[n] = '0;
      if (w_ready && (w_rd_addr[n] != '0) &&
          (32'(w_rd_addr[n]) < NUM_REGS)) begin
        if ((BYPASS != 0) && wr_en &&
            (wr_reg == w_rd_addr[n])) begin
          w_rd_data[n] = wr_data;
        end else begin
          w_rd_data[n] = r_regs[w_rd_addr[n]];
        end
      end
    end
  end

  assign rd_data_1 = w_rd_data[0];
  assign rd_data_2 = w_rd_data[1];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file with
// and without write-to-read bypass.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [4:0]  rd_reg_1;
  logic [4:0]  rd_reg_2;
  logic [31:0] a_rd1, a_rd2;
  logic [31:0] b_rd1, b_rd2;
  logic        a_done, b_done;

  register_file #(.BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en),
    .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_reg_1(rd_reg_1), .rd_reg_2(rd_reg_2),
    .rd_data_1(a_rd1), .rd_data_2(a_rd2),
    .init_done(a_done)
  );

  register_file #(.BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en),
    .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_reg_1(rd_reg_1), .rd_reg_2(rd_reg_2),
    .rd_data_1(b_rd1), .rd_data_2(b_rd2),
    .init_done(b_done)
  );

  typedef struct {
    logic [31:0] a1, a2, b1, b2;
    logic        done;
  } exp_t;

  exp_t        q[$];
  event        ev_chk;
  int          errors = 0;
  int          checks = 0;

  // Reference: a plain array plus a count of
  // posedges since reset was last released.
  logic [31:0] m_regs [32];
  int          m_cnt   = 0;
  bit          m_known = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rd(
    input logic [4:0]  a,
    input bit          byp,
    input bit          we,
    input logic [4:0]  wa,
    input logic [31:0] wd
  );
    if (m_cnt < 31 || a == 0) return 32'h0;
    if (byp && we && wa == a) return wd;
    return m_regs[a];
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(ev_chk);
      if (q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL sb_empty: got 0 expected >0");
      end else begin
        e = q.pop_front();
        chk("done_a", 32'(a_done), 32'(e.done));
        chk("done_b", 32'(b_done), 32'(e.done));
        chk("rd1_byp", a_rd1, e.a1);
        chk("rd2_byp", a_rd2, e.a2);
        chk("rd1_nob", b_rd1, e.b1);
        chk("rd2_nob", b_rd2, e.b2);
      end
    end
  end

  task automatic step(input bit          r,
                      input bit          we,
                      input logic [4:0]  wa,
                      input logic [31:0] wd,
                      input logic [4:0]  r1,
                      input logic [4:0]  r2);
    exp_t e;
    @(negedge clk);
    rst = r; wr_en = we; wr_reg = wa;
    wr_data = wd; rd_reg_1 = r1; rd_reg_2 = r2;
    #2;
    if (m_known) begin
      e.done = (m_cnt >= 31);
      e.a1 = exp_rd(r1, 1, we, wa, wd);
      e.a2 = exp_rd(r2, 1, we, wa, wd);
      e.b1 = exp_rd(r1, 0, we, wa, wd);
      e.b2 = exp_rd(r2, 0, we, wa, wd);
      q.push_back(e);
      -> ev_chk;
    end
    if (r) begin
      m_known = 1;
      m_cnt   = 0;
    end else if (m_known) begin
      if (m_cnt < 31) begin
        m_cnt++;
        m_regs[m_cnt] = 32'h0;
      end else if (we && wa != 0) begin
        m_regs[wa] = wd;
      end
    end
  endtask

  task automatic rnd_step(input bit allow_we);
    logic [4:0] wa, r1, r2;
    wa = 5'($urandom_range(0, 31));
    r1 = ($urandom_range(0, 3) == 0) ?
         wa : 5'($urandom_range(0, 31));
    r2 = 5'($urandom_range(0, 31));
    step(0, allow_we && $urandom_range(0, 1) == 1,
         wa, $urandom, r1, r2);
  endtask

  initial begin : driver
    rst = 1'b1; wr_en = 1'b0; wr_reg = '0;
    wr_data = '0; rd_reg_1 = '0; rd_reg_2 = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;

    step(1, 0, 0, 0, 0, 0);
    // Clear: writes must be dropped, incl. x3
    step(0, 1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3);
    for (int i = 0; i < 30; i++) rnd_step(1);
    for (int i = 0; i < 32; i++)
      step(0, 0, 0, 0, 5'(i), 5'(31 - i));

    step(0, 1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2);
    step(0, 0, 0, 0, 5'd5, 5'd5);
    step(0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    step(0, 0, 0, 0, 5'd0, 5'd0);
    step(0, 1, 5'd7, 32'h12345678, 5'd7, 5'd7);
    step(0, 0, 0, 0, 5'd7, 5'd3);

    for (int i = 0; i < 300; i++) rnd_step(1);

    for (int i = 1; i < 32; i++)
      step(0, 1, 5'(i), $urandom, 5'(i), 5'(i - 1));
    step(1, 0, 0, 0, 5'd4, 5'd9);
    for (int i = 0; i < 10; i++) rnd_step(1);
    step(1, 0, 0, 0, 5'd4, 5'd9);
    for (int i = 0; i < 31; i++) rnd_step(1);
    for (int i = 0; i < 32; i++)
      step(0, 0, 0, 0, 5'(i), 5'(i));

    for (int i = 0; i < 200; i++) rnd_step(1);

    #3;
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL sb_drain: got %0d expected 0",
               q.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
